// File: rtl/keypad_scanner.sv
// Purpose : scans a 4x4 active-low matrix keypad, debounces it and emits one key event per press.
// Latency : press accepted on the DEBOUNCE_SCANS-th agreeing tick; key_valid pulses 1 cycle later.
// Backpres: none. key_valid is a single-cycle pulse and key_code holds until the next press.
//
// Ports
//   clk       system clock (100 MHz)
//   rst_n     asynchronous active-low reset, released synchronously
//   row[3:0]  keypad rows, active low, asynchronous to clk
//   col[3:0]  column drive, active low, exactly one bit low
//   key_code  {row_idx, col_idx} of the last accepted press
//   key_valid one-cycle pulse per accepted press
//   key_held  high from accept until the release has been debounced
module keypad_scanner #(
    parameter int SCAN_DIV       = 16384,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       sync1, row_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       col_idx, col_idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [1:0]       cand_row, cand_row_nxt;
    logic [3:0]       key_code_nxt;
    logic             key_valid_nxt;
    logic             key_held_nxt;
    logic [2:0]       zeros;
    logic [1:0]       row_idx;
    logic             single;
    logic             idle;

    // Two-flop synchronizer; rows idle high so reset to all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'b1111;
            row_s <= 4'b1111;
        end else begin
            sync1 <= row;
            row_s <= sync1;
        end
    end

    // Free-running column-slot divider.
    assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Sample qualification: count low rows and locate the (last) low one.
    // row_idx is only meaningful when exactly one row is low.
    always_comb begin
        zeros   = 3'd0;
        row_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            zeros = zeros + {2'b00, ~row_s[i]};
            if (!row_s[i]) begin
                row_idx = i[1:0];
            end
        end
    end

    assign single  = (zeros == 3'd1);
    assign idle    = (zeros == 3'd0);
    assign cnt_inc = cnt + 1'b1;

    // Next-state / output logic. Everything only moves on a tick.
    always_comb begin
        state_nxt     = state;
        col_idx_nxt   = col_idx;
        cnt_nxt       = cnt;
        cand_row_nxt  = cand_row;
        key_code_nxt  = key_code;
        key_valid_nxt = 1'b0;
        key_held_nxt  = key_held;

        case (state)
            SCAN: begin
                if (tick) begin
                    if (single) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            cand_row_nxt  = row_idx;
                            key_code_nxt  = {row_idx, col_idx};
                            key_valid_nxt = 1'b1;
                            key_held_nxt  = 1'b1;
                            cnt_nxt       = '0;
                            state_nxt     = PRESSED;
                        end else begin
                            cand_row_nxt = row_idx;
                            cnt_nxt      = CNT_W'(1);
                            state_nxt    = DEBOUNCE;
                        end
                    end else begin
                        col_idx_nxt = col_idx + 2'd1;
                    end
                end
            end

            DEBOUNCE: begin
                if (tick) begin
                    if (single && (row_idx == cand_row)) begin
                        if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                            key_code_nxt  = {cand_row, col_idx};
                            key_valid_nxt = 1'b1;
                            key_held_nxt  = 1'b1;
                            cnt_nxt       = '0;
                            state_nxt     = PRESSED;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt     = '0;
                        col_idx_nxt = col_idx + 2'd1;
                        state_nxt   = SCAN;
                    end
                end
            end

            PRESSED: begin
                // Column stays frozen; any low row counts as still pressed.
                if (tick) begin
                    if (idle) begin
                        if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                            key_held_nxt = 1'b0;
                            cnt_nxt      = '0;
                            col_idx_nxt  = col_idx + 2'd1;
                            state_nxt    = SCAN;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
            end

            default: begin
                cnt_nxt   = '0;
                state_nxt = SCAN;
            end
        endcase
    end

    // Column drive is registered from the next index so col and col_idx move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            col       <= 4'b1110;
            cnt       <= '0;
            cand_row  <= 2'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            col_idx   <= col_idx_nxt;
            col       <= ~(4'b0001 << col_idx_nxt);
            cnt       <= cnt_nxt;
            cand_row  <= cand_row_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            key_held  <= key_held_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
// keys[{r,c}] = 1 means the switch at row r / column c is closed, so the
// index of a key equals the key_code the scanner must report for it.
module tb_keypad_scanner;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys;

    int tests;
    int fails;

    // Observations of the outputs, taken on posedge (pre-update values).
    int         vcnt;
    logic [3:0] vcode;
    int         wide_err;
    int         code_err;
    logic       prev_valid;
    logic [3:0] prev_code;

    keypad_scanner #(
        .SCAN_DIV       (8),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a row is pulled low when a closed switch connects it to the driven column.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (key_valid) begin
                vcnt  = vcnt + 1;
                vcode = key_code;
            end
            if (key_valid && prev_valid) wide_err = wide_err + 1;
            if ((key_code !== prev_code) && !key_valid) code_err = code_err + 1;
        end
        prev_valid = key_valid;
        prev_code  = key_code;
    end

    task automatic wait_held_low(input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (!key_held) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_vcnt(input int target, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (vcnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Waits for the first negedge at which col has just switched to value v.
    task automatic wait_col_enter(input logic [3:0] v, input int maxc, output bit ok);
        logic [3:0] last;
        ok   = 1'b0;
        last = col;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (col == v && last != v) begin
                ok = 1'b1;
                break;
            end
            last = col;
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_col;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (col !== 4'b1110) begin fails++; $display("FAIL reset_col got %b exp 1110", col); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", key_valid); end
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL reset_held got %b exp 0", key_held); end
        tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL reset_code got %h exp 0", key_code); end
        rst_n = 1'b1;
        // After posedge k, col_idx = (k/8)%4.
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            if (k == 7 || k == 8 || k == 15 || k == 16 || k == 24 || k == 32) begin
                exp_col = ~(4'b0001 << ((k / 8) % 4));
                tests++;
                if (col !== exp_col) begin
                    fails++;
                    $display("FAIL scan_step k=%0d got %b exp %b", k, col, exp_col);
                end
            end
        end
        // Mid-scan (col1 driven) asynchronous reset.
        #2 rst_n = 1'b0;
        #1;
        tests++; if (col !== 4'b1110) begin fails++; $display("FAIL midreset_col got %b exp 1110", col); end
        tests++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            fails++; $display("FAIL midreset_outs got v=%b h=%b exp 0 0", key_valid, key_held); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_press;
        bit ok;
        int n;
        int v0;
        v0 = vcnt;
        keys[6] = 1'b1;
        repeat (200) @(negedge clk);
        tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL clean_pulses got %0d exp 1", vcnt - v0); end
        tests++; if (vcode !== 4'h6) begin fails++; $display("FAIL clean_code got %h exp 6", vcode); end
        tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL clean_held got %b exp 1", key_held); end
        tests++; if (col !== 4'b1011) begin fails++; $display("FAIL clean_col_frozen got %b exp 1011", col); end
        keys[6] = 1'b0;
        wait_held_low(60, n);
        tests++; if (n < 19 || n > 26) begin fails++; $display("FAIL clean_release_delay got %0d exp 19..26", n); end
        tests++; if (col !== 4'b0111) begin fails++; $display("FAIL clean_resume_col got %b exp 0111", col); end
        tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL clean_no_extra got %0d exp 1", vcnt - v0); end
        ok = 1'b1;
    endtask

    task automatic test_bounce;
        bit ok;
        int n;
        int v0;
        v0 = vcnt;
        wait_col_enter(4'b1101, 60, ok);
        tests++; if (!ok) begin fails++; $display("FAIL bounce_sync got timeout exp col 1101"); end
        for (int t = 0; t < 6; t++) begin
            keys[9] = (t % 2 == 0);
            repeat (8) @(negedge clk);
        end
        tests++; if (vcnt != v0 || key_held !== 1'b0) begin
            fails++; $display("FAIL bounce_quiet got pulses=%0d held=%b exp 0 0", vcnt - v0, key_held); end
        keys[9] = 1'b1;
        wait_vcnt(v0 + 1, 100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL bounce_accept got timeout exp 1 pulse"); end
        tests++; if (vcode !== 4'h9) begin fails++; $display("FAIL bounce_code got %h exp 9", vcode); end
        repeat (30) @(negedge clk);
        keys[9] = 1'b0;
        wait_held_low(60, n);
        tests++; if (vcnt - v0 !== 1 || n < 0) begin
            fails++; $display("FAIL bounce_single got pulses=%0d rel=%0d exp 1 >=0", vcnt - v0, n); end
    endtask

    task automatic test_glitch;
        bit ok;
        int v0;
        v0 = vcnt;
        wait_col_enter(4'b1110, 60, ok);
        tests++; if (!ok) begin fails++; $display("FAIL glitch_sync got timeout exp col 1110"); end
        keys[8] = 1'b1;
        repeat (16) @(negedge clk);
        keys[8] = 1'b0;
        repeat (16) @(negedge clk);
        tests++; if (vcnt != v0) begin fails++; $display("FAIL glitch_pulse got %0d exp 0", vcnt - v0); end
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL glitch_held got %b exp 0", key_held); end
        wait_col_enter(4'b0111, 40, ok);
        tests++; if (!ok) begin fails++; $display("FAIL glitch_scan_adv got stuck col=%b exp 0111 reached", col); end
    endtask

    task automatic test_ghost;
        bit ok;
        int n;
        int v0;
        v0 = vcnt;
        keys[0]  = 1'b1;
        keys[12] = 1'b1;
        repeat (80) @(negedge clk);
        tests++; if (vcnt != v0 || key_held !== 1'b0) begin
            fails++; $display("FAIL ghost_reject got pulses=%0d held=%b exp 0 0", vcnt - v0, key_held); end
        wait_col_enter(4'b1110, 40, ok);
        tests++; if (!ok) begin fails++; $display("FAIL ghost_cycling got stuck col=%b exp cycling", col); end
        keys[12] = 1'b0;
        wait_vcnt(v0 + 1, 100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL ghost_accept got timeout exp 1 pulse"); end
        tests++; if (vcode !== 4'h0 || key_code !== 4'h0) begin
            fails++; $display("FAIL ghost_code got %h exp 0", vcode); end
        keys[0] = 1'b0;
        wait_held_low(60, n);
        tests++; if (n < 0) begin fails++; $display("FAIL ghost_release got timeout exp held low"); end
    endtask

    task automatic test_hold_release_bounce;
        bit ok;
        int n;
        int v0;
        v0 = vcnt;
        keys[15] = 1'b1;
        wait_vcnt(v0 + 1, 100, ok);
        tests++; if (!ok || vcode !== 4'hF) begin
            fails++; $display("FAIL hold_accept got ok=%0d code=%h exp 1 F", ok, vcode); end
        repeat (50) @(negedge clk);
        keys[15] = 1'b0;
        repeat (16) @(negedge clk);
        keys[15] = 1'b1;
        repeat (8) @(negedge clk);
        tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL hold_rebounce_held got %b exp 1", key_held); end
        keys[15] = 1'b0;
        wait_held_low(60, n);
        tests++; if (n < 19 || n > 26) begin fails++; $display("FAIL hold_release_delay got %0d exp 19..26", n); end
        tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL hold_no_second got %0d exp 1", vcnt - v0); end
        keys[15] = 1'b1;
        wait_vcnt(v0 + 2, 100, ok);
        tests++; if (!ok || vcode !== 4'hF) begin
            fails++; $display("FAIL hold_second_press got ok=%0d code=%h exp 1 F", ok, vcode); end
        keys[15] = 1'b0;
        wait_held_low(60, n);
    endtask

    task automatic test_reset_while_held;
        bit ok;
        int v0;
        v0 = vcnt;
        keys[5] = 1'b1;
        wait_vcnt(v0 + 1, 100, ok);
        tests++; if (!ok || key_held !== 1'b1) begin
            fails++; $display("FAIL rsthold_setup got ok=%0d held=%b exp 1 1", ok, key_held); end
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (key_held !== 1'b0 || key_code !== 4'h0 || col !== 4'b1110) begin
            fails++; $display("FAIL rsthold_clear got h=%b code=%h col=%b exp 0 0 1110", key_held, key_code, col); end
        keys[5] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        tests++; if (vcnt - v0 !== 1 || key_held !== 1'b0) begin
            fails++; $display("FAIL rsthold_after got pulses=%0d held=%b exp 1 0", vcnt - v0, key_held); end
    endtask

    task automatic test_output_integrity;
        tests++; if (wide_err != 0) begin fails++; $display("FAIL valid_width got %0d wide pulses exp 0", wide_err); end
        tests++; if (code_err != 0) begin fails++; $display("FAIL code_stable got %0d stray changes exp 0", code_err); end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        vcnt       = 0;
        vcode      = 4'h0;
        wide_err   = 0;
        code_err   = 0;
        prev_valid = 1'b0;
        prev_code  = 4'h0;
        keys       = 16'h0000;
        rst_n      = 1'b0;

        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_ghost();
        test_hold_release_bounce();
        test_reset_while_held();
        test_output_integrity();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad used as the lift's floor-call and function panel: drives columns, reads rows, debounces, and emits one decoded key event per physical press.
- Multiplexes the column drive in the same way the seven-segment driver multiplexes digit anodes, using the same 100 MHz `clk`.
- Sits between the keypad pins and the lift controller FSM. The controller consumes `key_valid`/`key_code`.

Parameters:
- SCAN_DIV, 16384, clk cycles per column slot; minimum 4.
- DEBOUNCE_SCANS, 4, consecutive agreeing samples needed to accept a press or a release; minimum 1.

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous active-low reset
- row  input  4  keypad rows, active low, externally pulled up; asynchronous to clk
- col  output  4  column drive, active low, one-hot-low; exactly one bit low at all times
- key_code  output  4  decoded key = {row_idx[1:0], col_idx[1:0]}; held until the next accepted press
- key_valid  output  1  one-cycle pulse when a debounced press is accepted
- key_held  output  1  high while the accepted key remains pressed (until its release is debounced)

Behaviour:
- Reset: on async assertion of rst_n, all of the following take effect immediately:
  - state=SCAN, col_idx=0, col=4'b1110
  - div counter=0, debounce counter=0
  - key_code=0, key_valid=0, key_held=0
  - synchronizer flops=4'b1111
- Reset release is used synchronously.
- Reset mid-operation abandons any debounce or held key with no key_valid pulse.
- Input sync: row passes through a 2-flop synchronizer to give row_s. All decisions use row_s only.
- Divider: counts 0..SCAN_DIV-1 and wraps. tick=1 on the cycle where the count equals SCAN_DIV-1. The divider runs freely in all states.
- Column drive: col=~(4'b0001<<col_idx), registered. col_idx changes only on a tick and only as stated below.
- Sample qualification: on a tick, a sample is "single" when exactly one bit of row_s is 0. row_idx is the index of that bit.
  - Zero low bits means "idle".
  - Two or more low bits means "ghost". Ghost samples are never accepted.
- State SCAN, on tick:
  - single: latch cand_row=row_idx, set debounce count=1, hold col_idx, go to DEBOUNCE.
  - If DEBOUNCE_SCANS=1, accept immediately instead (see accept).
  - idle or ghost: col_idx <= col_idx+1, mod 4 (wraps 3->0).
- State DEBOUNCE, on tick:
  - single with row_idx==cand_row: increment count; when count reaches DEBOUNCE_SCANS, accept.
  - anything else: count=0, col_idx+1, back to SCAN, no output change.
- Accept:
  - Next cycle: key_code={cand_row, col_idx}, key_valid=1 for exactly one cycle, key_held=1, state=PRESSED, count=0.
  - col_idx stays frozen while PRESSED.
- State PRESSED, on tick:
  - idle: increment release count; when it reaches DEBOUNCE_SCANS, key_held=0 on the next cycle, col_idx+1, go to SCAN.
  - any low row (same key, a bounce, or another key in this column): release count=0, remain PRESSED.
- Keys in other columns are not observed while PRESSED, so there is no rollover. Exactly one key_valid is produced per press regardless of bounce or hold duration.
- Latency:
  - Press accepted no earlier than DEBOUNCE_SCANS ticks after row_s goes low within the driven column.
  - key_valid appears 1 cycle after the accepting tick.
  - Worst-case detect delay adds up to 4 column slots.
- key_code never changes except at accept.

Test Plan:
- Bench parameters: SCAN_DIV=8, DEBOUNCE_SCANS=3.
- Reset: assert rst_n=0 mid-scan -> col=4'b1110, key_valid=0, key_held=0, key_code=0 immediately. After release, col steps 1110->1101->1011->0111->1110, 8 cycles per slot.
- Clean press: model switch at row1/col2 (row[1]=0 only while col[2]=0), held 200 cycles -> exactly one key_valid pulse, key_code=4'h6, key_held=1 until 3 idle ticks after release, then scanning resumes at col_idx=3.
- Bounce: row toggles on alternate ticks for 6 ticks, then stable -> no key_valid during bouncing; one key_valid with the correct code after 3 stable ticks.
- Short glitch: press lasting 2 ticks -> no key_valid, key_held stays 0, scan advances.
- Ghost: row[0] and row[3] both low in col0 -> never accepted, col keeps cycling. Removing row[3] -> key_code=4'h0 accepted.
- Hold/release bounce: key 4'hF (row3/col3) held; release with 1-tick rebounce -> key_held stays 1 until 3 consecutive idle ticks; no second key_valid. A second press then gives a new pulse.
